fetch: RTL and testbench
========================

FETCH -- requirements
Module: fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h00000000, first fetch address after reset.
REQ-002 Parameter DEPTH, default 2, instruction-buffer entries; also the outstanding-request limit.
REQ-003 clk  in  1  single clock, all state on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 branch_taken  in  1  redirect request from jump stage.
REQ-006 trap_taken  in  1  trap/trap-return redirect from jump stage.
REQ-007 jump_target  in  32  redirect address.
REQ-008 imem_req_valid  out  1  fetch request valid.
REQ-009 imem_req_ready  in  1  memory accepts request.
REQ-010 imem_addr  out  32  fetch address.
REQ-011 imem_rsp_valid  in  1  response valid; responses return in request order, at least 1 cycle after acceptance.
REQ-012 imem_rsp_data  in  32  instruction word.
REQ-013 ins_valid  out  1  instruction available to decode.
REQ-014 ins_ready  in  1  decode consumes the instruction.
REQ-015 ins  out  32  instruction word.
REQ-016 ins_pc  out  32  address of ins.
REQ-017 ins_misalign  out  1  ins_pc is not word aligned.
REQ-018 pipe_flush  out  1  younger instructions downstream are invalid this cycle.

Function
REQ-019 redirect = branch_taken || trap_taken; on redirect, next fetch PC = jump_target.
REQ-020 Fetch PC advances by 4 on each accepted request (imem_req_valid && imem_req_ready), wrapping modulo 2^32.
REQ-021 imem_req_valid asserts only when outstanding + buffer count < DEPTH, no redirect this cycle, and fetch PC[1:0] == 0.
REQ-022 imem_addr = fetch PC; imem_addr and imem_req_valid hold stable while imem_req_valid && !imem_req_ready.
REQ-023 Response writes {data, pc} into the FIFO unless it belongs to a killed request.
REQ-024 On redirect: FIFO emptied, all outstanding requests marked killed (drop counter = outstanding count), killed responses discarded and never forwarded.
REQ-025 A request accepted and a response in the same cycle adjust the outstanding count by net zero.
REQ-026 ins_valid = FIFO not empty; ins/ins_pc = head; pop on ins_valid && ins_ready; push and pop in the same cycle keep count unchanged.
REQ-027 FIFO full: no new request issued (REQ-021 guarantees no overflow).
REQ-028 pipe_flush is registered: high for exactly one cycle after any redirect cycle; back-to-back redirects keep it high.
REQ-029 Redirect with jump_target[1:0] != 0: no request issued; after the flush cycle, ins_valid=1, ins=32'h00000013, ins_pc=jump_target, ins_misalign=1, held until the next redirect.
REQ-030 Redirect and response in the same cycle: the response is dropped.
REQ-031 Redirect while a request is stalled (imem_req_valid && !imem_req_ready): request withdrawn next cycle; this is the only permitted withdrawal.
REQ-032 Redirect-to-first-request latency: 1 cycle (request for jump_target on the cycle after redirect).

Reset
REQ-033 During reset: fetch PC=RESET_PC, FIFO empty, outstanding=0, drop=0, misalign state clear.
REQ-034 During reset all outputs are 0: imem_req_valid, ins_valid, ins_misalign, pipe_flush, ins, ins_pc; imem_addr=RESET_PC.
REQ-035 First request issues on the first clock edge after rst_n deasserts.
REQ-036 Reset mid-transaction abandons in-flight requests; the memory is reset together with fetch.

Structure
REQ-037 The shared package holds the NOP encoding 32'h00000013 and RESET_PC default, next to the existing TRAP_* and COND_* constants.
REQ-038 Sub-module fetch_fifo implements the DEPTH-entry {pc, ins} FIFO with count, full and empty outputs.

Verification
REQ-039 Reset release, ready=1, 1-cycle memory, ins_ready=1 -> imem_addr 0,4,8; ins_pc 0,4,8 in order; no bubbles after the first response.
REQ-040 ins_ready=0 for 5 cycles -> exactly 2 instructions buffered, imem_req_valid low, no loss; order restored on release.
REQ-041 branch_taken with jump_target=32'h100 while 2 requests outstanding -> pipe_flush high 1 cycle, both stale responses dropped, next ins_pc=32'h100.
REQ-042 trap_taken with jump_target=32'h102 -> after flush, ins=32'h00000013, ins_pc=32'h102, ins_misalign=1, no imem request.
REQ-043 imem_req_ready=0 for 3 cycles -> imem_addr stable; redirect during the stall -> request withdrawn, new address = jump_target.
REQ-044 rst_n asserted mid-stream -> all outputs zero immediately (asynchronous), fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared core constants and the fetch-buffer entry type.
// Imported by the fetch stage and its instruction FIFO.
package fetch_pkg;

   localparam logic [31:0] TRAP_ILLEGAL   = 32'd2;
   localparam logic [31:0] TRAP_BREAK     = 32'd3;
   localparam logic [31:0] TRAP_ECALL     = 32'd11;

   localparam logic [2:0]  COND_EQ        = 3'b000;
   localparam logic [2:0]  COND_NE        = 3'b001;
   localparam logic [2:0]  COND_LT        = 3'b100;
   localparam logic [2:0]  COND_GE        = 3'b101;

   localparam logic [31:0] FETCH_NOP      = 32'h0000_0013;
   localparam logic [31:0] FETCH_RESET_PC = 32'h0000_0000;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] ins;
   } fetch_ent_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small in-order buffer of fetched {pc, ins} pairs.
// Flush drops all entries; storage contents are left as-is.
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int DEPTH = 2,
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CW = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          flush_i,
   input  logic          push_i,
   input  fetch_ent_t    din_i,
   input  logic          pop_i,
   output fetch_ent_t    head_o,
   output logic [CW-1:0] count_o,
   output logic          full_o,
   output logic          empty_o
);

   fetch_ent_t    mem_q [DEPTH];
   logic [AW-1:0] wp_q, rp_q;
   logic [CW-1:0] cnt_q;

   function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wp_q  <= '0;
         rp_q  <= '0;
         cnt_q <= '0;
      end else if (flush_i) begin
         wp_q  <= '0;
         rp_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (push_i) begin
            mem_q[wp_q] <= din_i;
            wp_q        <= nxt(wp_q);
         end
         if (pop_i) rp_q <= nxt(rp_q);
         cnt_q <= cnt_q + CW'(push_i) - CW'(pop_i);
      end
   end

   assign head_o  = mem_q[rp_q];
   assign count_o = cnt_q;
   assign full_o  = (cnt_q == CW'(DEPTH));
   assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/fetch.sv
// Instruction fetch stage: issues in-order imem requests,
// buffers responses, and handles redirects and misaligned targets.
module fetch
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = FETCH_RESET_PC,
   parameter int          DEPTH    = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        branch_taken,
   input  logic        trap_taken,
   input  logic [31:0] jump_target,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   output logic        ins_valid,
   input  logic        ins_ready,
   output logic [31:0] ins,
   output logic [31:0] ins_pc,
   output logic        ins_misalign,
   output logic        pipe_flush
);

   localparam int          CW    = $clog2(DEPTH + 1);
   localparam logic [CW:0] LIMIT = (CW + 1)'(DEPTH);

   logic [31:0]   pc_q, pc_d;
   logic [31:0]   rpc_q, rpc_d;
   logic [CW-1:0] os_q, os_d;
   logic [CW-1:0] drop_q, drop_d;
   logic          mis_q, mis_d;
   logic          flush_q;

   logic          redirect, acc, live, pop;
   logic          full, empty;
   logic [CW-1:0] cnt;
   logic [CW:0]   used;
   fetch_ent_t    head, din;

   assign redirect = branch_taken || trap_taken;
   assign pop      = !empty && ins_ready;
   assign live     = imem_rsp_valid && !redirect
                     && (drop_q == '0);

   // A slot freed by this cycle's pop may be reused at once.
   assign used = {1'b0, os_q} + {1'b0, cnt}
                 - {{CW{1'b0}}, pop};

   assign imem_req_valid = rst_n && !redirect && !mis_q
                           && (pc_q[1:0] == 2'b00)
                           && (!full || pop)
                           && (used < LIMIT);
   assign imem_addr = pc_q;
   assign acc       = imem_req_valid && imem_req_ready;

   assign din = '{pc: rpc_q, ins: imem_rsp_data};

   fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .flush_i (redirect),
      .push_i  (live),
      .din_i   (din),
      .pop_i   (pop),
      .head_o  (head),
      .count_o (cnt),
      .full_o  (full),
      .empty_o (empty)
   );

   always_comb begin
      pc_d   = pc_q;
      rpc_d  = rpc_q;
      mis_d  = mis_q;
      drop_d = drop_q;
      os_d   = os_q + CW'(acc) - CW'(imem_rsp_valid);
      if (redirect) begin
         pc_d   = jump_target;
         rpc_d  = jump_target;
         mis_d  = |jump_target[1:0];
         drop_d = os_d;
      end else begin
         if (acc)  pc_d  = pc_q + 32'd4;
         if (live) rpc_d = rpc_q + 32'd4;
         if (imem_rsp_valid && (drop_q != '0))
            drop_d = drop_q - CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q    <= RESET_PC;
         rpc_q   <= RESET_PC;
         os_q    <= '0;
         drop_q  <= '0;
         mis_q   <= 1'b0;
         flush_q <= 1'b0;
      end else begin
         pc_q    <= pc_d;
         rpc_q   <= rpc_d;
         os_q    <= os_d;
         drop_q  <= drop_d;
         mis_q   <= mis_d;
         flush_q <= redirect;
      end
   end

   // A misaligned target is presented as a held NOP after the flush.
   assign ins_valid    = !empty || (mis_q && !flush_q);
   assign ins          = mis_q ? FETCH_NOP : head.ins;
   assign ins_pc       = mis_q ? pc_q : head.pc;
   assign ins_misalign = mis_q && !flush_q;
   assign pipe_flush   = flush_q;

endmodule

// File: tb/tb_fetch.sv
// Bench for fetch: in-order memory model plus a stream-level
// reference of expected requests and delivered instructions.
module tb_fetch;

   localparam int DEPTH = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        branch_taken = 1'b0;
   logic        trap_taken = 1'b0;
   logic [31:0] jump_target = '0;
   logic        imem_req_valid;
   logic        imem_req_ready = 1'b0;
   logic [31:0] imem_addr;
   logic        imem_rsp_valid = 1'b0;
   logic [31:0] imem_rsp_data = '0;
   logic        ins_valid;
   logic        ins_ready = 1'b0;
   logic [31:0] ins;
   logic [31:0] ins_pc;
   logic        ins_misalign;
   logic        pipe_flush;

   always #5 clk = ~clk;

   fetch #(.RESET_PC(32'h0), .DEPTH(DEPTH)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .branch_taken   (branch_taken),
      .trap_taken     (trap_taken),
      .jump_target    (jump_target),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_addr      (imem_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .ins_valid      (ins_valid),
      .ins_ready      (ins_ready),
      .ins            (ins),
      .ins_pc         (ins_pc),
      .ins_misalign   (ins_misalign),
      .pipe_flush     (pipe_flush)
   );

   typedef struct {
      logic [31:0] addr;
      bit          killed;
   } req_t;

   req_t        mq[$];
   logic [31:0] acc_log[$];
   logic [31:0] con_log[$];
   bit          fl_log[$];
   int          buf_n;
   bit          mis;
   bit          flush_exp;
   logic [31:0] exp_fetch;
   logic [31:0] exp_next;
   int          iv_low;
   int          n_pass = 0;
   int          n_fail = 0;

   function automatic logic [31:0] memf(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'hC0DE_1357;
   endfunction

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] expv);
      assert (obs === expv) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: got %h want %h", tag, obs, expv);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      buf_n     = 0;
      mis       = 1'b0;
      flush_exp = 1'b0;
      exp_fetch = 32'h0;
      exp_next  = 32'h0;
   endtask

   task automatic clr_logs();
      acc_log.delete();
      con_log.delete();
      fl_log.delete();
   endtask

   task automatic rchk();
      chk("rst_req_valid", 32'(imem_req_valid), 32'h0);
      chk("rst_ins_valid", 32'(ins_valid), 32'h0);
      chk("rst_misalign", 32'(ins_misalign), 32'h0);
      chk("rst_flush", 32'(pipe_flush), 32'h0);
      chk("rst_ins", ins, 32'h0);
      chk("rst_ins_pc", ins_pc, 32'h0);
      chk("rst_addr", imem_addr, 32'h0);
   endtask

   // mm: 0 = respond asap, 1 = random delay, 2 = hold responses
   task automatic cyc(input bit br, input bit tr,
                      input logic [31:0] tgt,
                      input bit rdy, input bit irdy,
                      input int mm);
      bit   redir, ev, pop, erv, acc;
      int   used;
      req_t e;
      redir = br || tr;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
      if (mq.size() > 0 &&
          (mm == 0 || (mm == 1 && $urandom_range(3) != 0))) begin
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = memf(mq[0].addr);
      end
      branch_taken   = br;
      trap_taken     = tr;
      jump_target    = tgt;
      imem_req_ready = rdy;
      ins_ready      = irdy;
      #1;
      ev   = mis ? !flush_exp : (buf_n > 0);
      pop  = ev && irdy && !mis;
      used = mq.size() + buf_n - (pop ? 1 : 0);
      erv  = !redir && !mis && (used < DEPTH);
      chk("req_valid", 32'(imem_req_valid), 32'(erv));
      if (imem_req_valid) chk("imem_addr", imem_addr, exp_fetch);
      chk("pipe_flush", 32'(pipe_flush), 32'(flush_exp));
      chk("ins_valid", 32'(ins_valid), 32'(ev));
      chk("ins_misalign", 32'(ins_misalign),
          32'(mis && !flush_exp));
      if (ins_valid) begin
         chk("ins_pc", ins_pc, exp_next);
         chk("ins", ins, mis ? 32'h0000_0013 : memf(exp_next));
      end
      if (!ins_valid) iv_low++;
      if (imem_rsp_valid) begin
         e = mq.pop_front();
         if (!e.killed && !redir) buf_n++;
      end
      acc = imem_req_valid && rdy;
      if (acc) begin
         acc_log.push_back(imem_addr);
         mq.push_back('{addr: exp_fetch, killed: redir});
         exp_fetch += 32'd4;
      end
      if (ins_valid && irdy) con_log.push_back(ins_pc);
      if (pop) begin
         buf_n--;
         exp_next += 32'd4;
      end
      fl_log.push_back(pipe_flush);
      flush_exp = redir;
      if (redir) begin
         foreach (mq[i]) mq[i].killed = 1'b1;
         buf_n     = 0;
         exp_fetch = tgt;
         exp_next  = tgt;
         mis       = (tgt[1:0] != 2'b00);
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      logic [31:0] t;
      bit b1, b2;
      model_reset();
      #3 rchk();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // sequential stream, 1-cycle memory
      clr_logs();
      repeat (2) cyc(0, 0, 0, 1, 1, 0);
      iv_low = 0;
      repeat (6) cyc(0, 0, 0, 1, 1, 0);
      chk("t1_addr0", acc_log[0], 32'h0);
      chk("t1_addr1", acc_log[1], 32'h4);
      chk("t1_addr2", acc_log[2], 32'h8);
      chk("t1_pc0", con_log[0], 32'h0);
      chk("t1_pc1", con_log[1], 32'h4);
      chk("t1_pc2", con_log[2], 32'h8);
      chk("t1_bubbles", 32'(iv_low), 32'h0);

      // decode stall: buffer fills, no new requests
      clr_logs();
      repeat (5) cyc(0, 0, 0, 1, 0, 0);
      chk("t2_no_req", 32'(acc_log.size()), 32'h0);
      repeat (3) cyc(0, 0, 0, 0, 1, 2);
      chk("t2_buffered", 32'(con_log.size()), 32'h2);

      // branch with two requests outstanding
      repeat (3) cyc(0, 0, 0, 1, 1, 2);
      chk("t3_outstanding", 32'(mq.size()), 32'h2);
      cyc(1, 0, 32'h100, 1, 1, 0);
      clr_logs();
      repeat (6) cyc(0, 0, 0, 1, 1, 0);
      chk("t3_flush_hi", 32'(fl_log[0]), 32'h1);
      chk("t3_flush_lo", 32'(fl_log[1]), 32'h0);
      chk("t3_first_pc", con_log[0], 32'h100);

      // trap to misaligned target
      cyc(0, 1, 32'h102, 1, 1, 0);
      clr_logs();
      repeat (5) cyc(0, 0, 0, 1, 1, 0);
      chk("t4_no_req", 32'(acc_log.size()), 32'h0);
      chk("t4_held", 32'(con_log.size()), 32'h4);
      chk("t4_pc", con_log[0], 32'h102);

      // memory stall, then redirect while stalled
      cyc(1, 0, 32'h200, 0, 1, 0);
      clr_logs();
      repeat (3) cyc(0, 0, 0, 0, 1, 0);
      chk("t5_stalled", 32'(acc_log.size()), 32'h0);
      cyc(1, 0, 32'h300, 0, 1, 0);
      clr_logs();
      repeat (3) cyc(0, 0, 0, 1, 1, 0);
      chk("t5_new_addr", acc_log[0], 32'h300);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         b1 = ($urandom_range(40) == 0);
         b2 = ($urandom_range(60) == 0);
         t  = $urandom & 32'h0000_0FFC;
         if ($urandom_range(3) == 0) t[1:0] = 2'($urandom_range(3));
         if ($urandom_range(15) == 0) t = 32'hFFFF_FFF0;
         cyc(b1, b2, t, $urandom_range(3) != 0,
             $urandom_range(3) != 0, 1);
      end

      // asynchronous reset mid-stream
      cyc(1, 0, 32'h40, 1, 1, 0);
      repeat (4) cyc(0, 0, 0, 1, 1, 0);
      #2 rst_n = 1'b0;
      branch_taken   = 1'b0;
      trap_taken     = 1'b0;
      imem_rsp_valid = 1'b0;
      #1 rchk();
      @(negedge clk);
      @(negedge clk);
      model_reset();
      rst_n = 1'b1;
      clr_logs();
      repeat (4) cyc(0, 0, 0, 1, 1, 0);
      chk("t7_restart_n", 32'(acc_log.size() != 0), 32'h1);
      chk("t7_restart_pc", acc_log[0], 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_pass + n_fail);
      $finish;
   end

endmodule
